// File: rtl/fifo_wr_arb_pkg.sv
// rtl/fifo_wr_arb_pkg.sv - shared state encoding and parameter defaults for the FIFO write arbiter
package fifo_wr_arb_pkg;

   localparam int N_REQ_DEF     = 4;
   localparam int D_WIDTH_DEF   = 8;
   localparam int MAX_BURST_DEF = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// rtl/fifo_wr_arb_rr_pick.sv - cyclic first-set-bit search starting at a given index
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic          found,
   output logic [IW-1:0] idx
);

   logic [IW:0]   sum;
   logic [IW-1:0] cand;

   // Walk offsets from farthest to nearest so the nearest hit is written last and wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      sum   = '0;
      cand  = '0;
      for (int k = N - 1; k >= 0; k--) begin
         sum = {1'b0, start} + (IW + 1)'(k);
         if (sum >= (IW + 1)'(N)) begin
            sum = sum - (IW + 1)'(N);
         end
         cand = sum[IW-1:0];
         if (req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - round-robin burst arbiter sharing one FIFO write port among N_REQ producers
module fifo_wr_arb
   import fifo_wr_arb_pkg::*;
#(
   parameter int N_REQ     = N_REQ_DEF,
   parameter int D_WIDTH   = D_WIDTH_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic                       clk,
   input  logic                       n_rst,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*D_WIDTH-1:0]   req_data,
   output logic [N_REQ-1:0]           req_ack,
   input  logic                       fifo_full,
   output logic                       fifo_w_en,
   output logic [D_WIDTH-1:0]         fifo_w_data,
   output logic [$clog2(N_REQ)-1:0]   owner,
   output logic                       busy
);

   localparam int OW = $clog2(N_REQ);
   localparam int CW = $clog2(MAX_BURST) + 1;

   state_t          state;
   state_t          state_nxt;
   logic [OW-1:0]   owner_nxt;
   logic [OW-1:0]   last_owner;
   logic [OW-1:0]   last_owner_nxt;
   logic [OW-1:0]   start;
   logic [OW-1:0]   pick_idx;
   logic            pick_found;
   logic [CW-1:0]   burst_cnt;
   logic [CW-1:0]   cnt_nxt;
   logic            accept;

   // Explicit wrap keeps the search start legal for non-power-of-two N_REQ.
   assign start = (last_owner == OW'(N_REQ - 1)) ? '0 : last_owner + 1'b1;

   rr_pick #(
      .N  (N_REQ),
      .IW (OW)
   ) u_pick (
      .req   (req_valid),
      .start (start),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= IDLE;
         owner      <= '0;
         last_owner <= OW'(N_REQ - 1);
         burst_cnt  <= '0;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         last_owner <= last_owner_nxt;
         burst_cnt  <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      owner_nxt      = owner;
      last_owner_nxt = last_owner;
      cnt_nxt        = burst_cnt;
      accept         = 1'b0;
      busy           = 1'b0;
      fifo_w_en      = 1'b0;
      req_ack        = '0;
      fifo_w_data    = req_data[int'(owner)*D_WIDTH +: D_WIDTH];
      case (state)
         IDLE: begin
            if (pick_found) begin
               state_nxt = BURST;
               owner_nxt = pick_idx;
               cnt_nxt   = '0;
            end
         end
         BURST: begin
            busy           = 1'b1;
            accept         = req_valid[owner] & ~fifo_full;
            fifo_w_en      = accept;
            req_ack[owner] = accept;
            if (accept) begin
               cnt_nxt = burst_cnt + 1'b1;
            end
            // A stalled owner keeps the grant; only a dropped request or a full burst releases it.
            if (!req_valid[owner] || (accept && burst_cnt == CW'(MAX_BURST - 1))) begin
               state_nxt      = IDLE;
               last_owner_nxt = owner;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of producers sharing one syn_FIFO write port (2..8).
REQ-002 Parameter D_WIDTH, default 8, data word width; equals the FIFO d_width.
REQ-003 Parameter MAX_BURST, default 4, maximum words per grant (1..16).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 n_rst  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  N_REQ  bit i: producer i has a word ready.
REQ-007 req_data  input  N_REQ*D_WIDTH  producer i word at bits [i*D_WIDTH +: D_WIDTH].
REQ-008 req_ack  output  N_REQ  one-hot or zero; bit i: producer i word is written this cycle.
REQ-009 fifo_full  input  1  FIFO isFull.
REQ-010 fifo_w_en  output  1  FIFO write enable.
REQ-011 fifo_w_data  output  D_WIDTH  FIFO write data.
REQ-012 owner  output  clog2(N_REQ)  index of the current grant holder; valid while busy=1.
REQ-013 busy  output  1  high in state BURST.

Function
REQ-014 The FSM SHALL have two states: IDLE (no owner) and BURST (owner locked).
REQ-015 In IDLE with any req_valid set, the next owner SHALL be the first set bit searched cyclically from last_owner+1 (mod N_REQ); the FSM enters BURST next cycle with burst_cnt=0.
REQ-016 In IDLE, req_ack, fifo_w_en and busy SHALL be 0; arbitration latency is exactly 1 cycle from IDLE to the first possible write.
REQ-017 In BURST, accept = req_valid[owner] & !fifo_full; req_ack[owner] and fifo_w_en SHALL equal accept combinationally, and fifo_w_data SHALL equal the owner's slice of req_data.
REQ-018 Each accept SHALL increment burst_cnt; burst_cnt width is clog2(MAX_BURST)+1, with no wrap.
REQ-019 BURST -> IDLE SHALL occur on an accept with burst_cnt==MAX_BURST-1, or in any cycle where req_valid[owner]==0; last_owner SHALL be loaded with owner on that transition.
REQ-020 While fifo_full=1 with owner valid, the FSM SHALL remain in BURST, with no accept and burst_cnt held; there is no timeout.
REQ-021 At most one word SHALL be written per cycle; req_ack bits for non-owners SHALL always be 0.
REQ-022 Requests arriving during BURST SHALL wait; no preemption.
REQ-023 Owner index arithmetic SHALL wrap modulo N_REQ for non-power-of-two N_REQ (index N_REQ-1 -> 0).
REQ-024 With a single requester continuously valid, it SHALL be re-granted after each IDLE cycle, giving MAX_BURST words per MAX_BURST+1 cycles.

Reset
REQ-025 On n_rst=0, state SHALL asynchronously become IDLE, with owner=0, last_owner=N_REQ-1 (so requester 0 is searched first), burst_cnt=0; busy, fifo_w_en and req_ack SHALL be 0 for the whole time reset is asserted.
REQ-026 Reset asserted mid-burst SHALL abort the burst; a word presented in the reset cycle is not written; the first grant after release follows REQ-015.

Structure
REQ-027 A shared package SHALL hold the state encoding (IDLE=1'b0, BURST=1'b1) and the parameter defaults.
REQ-028 The cyclic priority search SHALL be one combinational sub-module, rr_pick (inputs: req vector and start index; outputs: found and index).
REQ-029 The block SHALL connect directly to syn_FIFO (fifo_w_en->w_en, fifo_w_data->w_data, isFull->fifo_full) with no extra buffering.

Verification
REQ-030 Reset, then req_valid=4'b0000 -> busy=0, fifo_w_en=0 indefinitely.
REQ-031 req_valid=4'b1111 held, FIFO never full -> grant order 0,1,2,3,0; 4 writes per grant; each grant preceded by 1 idle cycle.
REQ-032 Only req 2 valid, data 8'hA5, fifo_full=1 for 3 cycles then 0 -> no write for 3 cycles, then 4 writes of 8'hA5 with req_ack=4'b0100.
REQ-033 Owner 1 drops req_valid after 2 accepts while req 3 is valid -> IDLE for 1 cycle, then owner=3.
REQ-034 n_rst pulsed low during the 3rd word of a burst -> outputs 0 immediately; after release, the first grant goes to the lowest valid index.
REQ-035 Random req/full traffic with a scoreboard -> every accepted word appears in the FIFO in order, no loss, and no producer starved beyond (N_REQ-1)*(MAX_BURST+1) non-full cycles.
